// File: rtl/sprite_program_driver.sv
// -----------------------------------------------------------------------------
// sprite_program_driver
//
// Initiator for the sprite-engine programming daisy chain. Game logic pushes
// sprite commands into a small queue. During vertical blank the driver pops
// them one at a time and places each on the chain bus. Every command is held
// with program_active=1 for CHAIN_LEN+1 cycles, which is long enough to ripple
// through every registered sprite_engine stage. Each command is followed by a
// one-cycle gap with the bus zeroed. A CLEAR_ALL command expands into a sweep
// of clear commands for ids 0..NUM_SPRITES-1. The sweep pauses between steps
// while vblank is low.
//
// Ports
//   clk                  in   1   system clock
//   reset                in   1   synchronous, active-high reset
//   vblank               in   1   display is in vertical blank
//   cmd_valid            in   1   command present
//   cmd_ready            out  1   queue can accept a command
//   cmd_op               in   2   00 SET, 01 CLEAR, 10 CLEAR_ALL, 11 NOP
//   cmd_id               in   6   target sprite id
//   cmd_addr             in   16  sprite bitmap base address (SET)
//   cmd_x / cmd_y        in   8   screen position (SET)
//   program_active       out  1   chain programming strobe
//   requested_sprite_id  out  6   id on chain bus
//   set_address          out  16  address on chain bus
//   setx / sety          out  8   position on chain bus
//   clear                out  1   clear-sprite flag on chain bus
//   busy                 out  1   queue non-empty or a command/sweep in flight
// -----------------------------------------------------------------------------
module sprite_program_driver #(
  parameter int CHAIN_LEN   = 8,
  parameter int NUM_SPRITES = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vblank,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_id,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  output logic        program_active,
  output logic [5:0]  requested_sprite_id,
  output logic [15:0] set_address,
  output logic [7:0]  setx,
  output logic [7:0]  sety,
  output logic        clear,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CHAIN_LEN + 2);
  localparam logic [5:0]    LAST_ID  = 6'(NUM_SPRITES - 1);
  localparam logic [CW-1:0] HOLD_END = CW'(CHAIN_LEN);

  typedef enum logic [1:0] {
    OP_SET       = 2'b00,
    OP_CLEAR     = 2'b01,
    OP_CLEAR_ALL = 2'b10,
    OP_NOP       = 2'b11
  } op_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  id;
    logic [15:0] addr;
    logic [7:0]  x;
    logic [7:0]  y;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP,
    SWEEP_WAIT
  } state_t;

  // Command queue. The pointers carry one extra wrap bit so that the full
  // condition can be told apart from the empty one.
  cmd_t          fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  cmd_t          head;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] hold_cnt;
  logic          sweeping;
  logic          sweep_more;

  logic [5:0]    bus_id;
  logic [15:0]   bus_addr;
  logic [7:0]    bus_x;
  logic [7:0]    bus_y;
  logic          bus_clr;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = fifo_mem[rd_ptr[AW-1:0]];

  // A full queue refuses the push even if a pop happens in the same cycle.
  // While reset is held the queue is about to be emptied, so it reads ready.
  assign cmd_ready  = reset || !fifo_full;
  assign push       = cmd_valid && !fifo_full && (op_t'(cmd_op) != OP_NOP);
  assign sweep_more = sweeping && (bus_id < LAST_ID);

  // NOTE: every signal written here is given a default first, so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && vblank) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_cnt == HOLD_END) state_next = GAP;
      end
      GAP: begin
        if (sweep_more) state_next = vblank ? DRIVE : SWEEP_WAIT;
        else            state_next = IDLE;
      end
      SWEEP_WAIT: begin
        if (vblank) state_next = DRIVE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the queue storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= cmd_t'{cmd_op, cmd_id, cmd_addr, cmd_x, cmd_y};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      hold_cnt <= '0;
      sweeping <= 1'b0;
      bus_id   <= '0;
      bus_addr <= '0;
      bus_x    <= '0;
      bus_y    <= '0;
      bus_clr  <= 1'b0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      // The hold counter restarts on every entry into DRIVE.
      hold_cnt <= (state == DRIVE) ? hold_cnt + 1'b1 : '0;

      if (pop) begin
        unique case (op_t'(head.op))
          OP_SET: begin
            bus_id   <= head.id;
            bus_addr <= head.addr;
            bus_x    <= head.x;
            bus_y    <= head.y;
            bus_clr  <= 1'b0;
            sweeping <= 1'b0;
          end
          OP_CLEAR: begin
            bus_id   <= head.id;
            bus_addr <= '0;
            bus_x    <= '0;
            bus_y    <= '0;
            bus_clr  <= 1'b1;
            sweeping <= 1'b0;
          end
          default: begin
            // CLEAR_ALL starts its sweep at id 0 whatever cmd_id says.
            // NOP never reaches the queue, so it cannot be popped.
            bus_id   <= '0;
            bus_addr <= '0;
            bus_x    <= '0;
            bus_y    <= '0;
            bus_clr  <= 1'b1;
            sweeping <= 1'b1;
          end
        endcase
      end else if (state == GAP && sweeping) begin
        // The next sweep id is prepared here. A paused sweep holds it in SWEEP_WAIT.
        if (sweep_more) bus_id   <= bus_id + 6'd1;
        else            sweeping <= 1'b0;
      end
    end
  end

  // The bus carries the command only while driving. It reads zero otherwise.
  assign program_active      = (state == DRIVE);
  assign requested_sprite_id = program_active ? bus_id   : '0;
  assign set_address         = program_active ? bus_addr : '0;
  assign setx                = program_active ? bus_x    : '0;
  assign sety                = program_active ? bus_y    : '0;
  assign clear               = program_active && bus_clr;
  assign busy                = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_sprite_program_driver.sv
module tb_sprite_program_driver;

  localparam int CL = 8;
  localparam int NS = 4;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        vblank;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_id;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic        program_active;
  logic [5:0]  requested_sprite_id;
  logic [15:0] set_address;
  logic [7:0]  setx;
  logic [7:0]  sety;
  logic        clear;
  logic        busy;

  sprite_program_driver #(.CHAIN_LEN(CL), .NUM_SPRITES(NS), .FIFO_DEPTH(FD)) dut (
    .clk                 (clk),
    .reset               (reset),
    .vblank              (vblank),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_op              (cmd_op),
    .cmd_id              (cmd_id),
    .cmd_addr            (cmd_addr),
    .cmd_x               (cmd_x),
    .cmd_y               (cmd_y),
    .program_active      (program_active),
    .requested_sprite_id (requested_sprite_id),
    .set_address         (set_address),
    .setx                (setx),
    .sety                (sety),
    .clear               (clear),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. It tracks a command queue, the number of strobe cycles
  // still owed to the current chain write, and where a clear sweep has got to.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  op;
    logic [5:0]  id;
    logic [15:0] addr;
    logic [7:0]  x;
    logic [7:0]  y;
  } cmd_s;

  cmd_s        mq[$];
  int          act_left  = 0;   // strobe cycles remaining for current write
  bit          in_gap    = 0;   // the one zeroed cycle after a write
  bit          waiting   = 0;   // sweep paused for vblank
  int          sweep_cur = -1;  // id of the sweep step in progress, -1 none
  bit          model_on  = 0;
  logic [5:0]  m_id;
  logic [15:0] m_addr;
  logic [7:0]  m_x;
  logic [7:0]  m_y;
  logic        m_clr;

  function automatic void m_start(input logic [5:0] id, input logic [15:0] a,
                                  input logic [7:0] x, input logic [7:0] y, input logic c);
    m_id = id; m_addr = a; m_x = x; m_y = y; m_clr = c;
    act_left = CL + 1;
  endfunction

  always @(posedge clk) begin
    bit   do_push;
    cmd_s c;
    do_push = cmd_valid && (mq.size() < FD) && (cmd_op != 2'b11);
    if (reset) begin
      mq.delete();
      act_left = 0; in_gap = 0; waiting = 0; sweep_cur = -1;
      model_on = 1;
    end else begin
      if (act_left > 0) begin
        act_left--;
        if (act_left == 0) in_gap = 1;
      end else if (in_gap) begin
        in_gap = 0;
        if (sweep_cur >= 0 && sweep_cur < NS - 1) begin
          sweep_cur++;
          if (vblank) m_start(6'(sweep_cur), 16'h0, 8'h0, 8'h0, 1'b1);
          else        waiting = 1;
        end else sweep_cur = -1;
      end else if (waiting) begin
        if (vblank) begin
          waiting = 0;
          m_start(6'(sweep_cur), 16'h0, 8'h0, 8'h0, 1'b1);
        end
      end else if (mq.size() > 0 && vblank) begin
        c = mq.pop_front();
        case (c.op)
          2'b00:   m_start(c.id, c.addr, c.x, c.y, 1'b0);
          2'b01:   m_start(c.id, 16'h0, 8'h0, 8'h0, 1'b1);
          default: begin sweep_cur = 0; m_start(6'd0, 16'h0, 8'h0, 8'h0, 1'b1); end
        endcase
      end
      if (do_push) begin
        c.op = cmd_op; c.id = cmd_id; c.addr = cmd_addr; c.x = cmd_x; c.y = cmd_y;
        mq.push_back(c);
      end
    end
  end

  // Every-cycle comparison at the falling edge, after the DUT has settled.
  always @(negedge clk) begin
    logic [41:0] got, want;
    bit act;
    if (model_on) begin
      act  = (act_left > 0);
      got  = {program_active, requested_sprite_id, set_address, setx, sety, clear, busy, cmd_ready};
      want = {act, act ? m_id : 6'h0, act ? m_addr : 16'h0, act ? m_x : 8'h0, act ? m_y : 8'h0,
              act && m_clr,
              (mq.size() > 0) || act || in_gap || waiting,
              reset || (mq.size() < FD)};
      check("model_outputs", 64'(got), 64'(want));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 2 time units after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cmd(input logic v, input logic [1:0] op, input logic [5:0] id,
                         input logic [15:0] a, input logic [7:0] x, input logic [7:0] y);
    cmd_valid = v; cmd_op = op; cmd_id = id; cmd_addr = a; cmd_x = x; cmd_y = y;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (busy && n < limit) begin step(); n++; end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic wait_active(input string name, input int limit);
    int n = 0;
    while (!program_active && n < limit) begin step(); n++; end
    check(name, 64'(program_active), 64'd1);
  endtask

  initial begin
    reset = 1'b1; vblank = 1'b0;
    set_cmd(1'b0, 2'b11, 6'd0, 16'h0, 8'h0, 8'h0);
    step();
    check("ready_in_reset", 64'(cmd_ready), 64'd1);
    step(); step();
    reset = 1'b0;
    step();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_active", 64'(program_active), 64'd0);

    // 1: single SET with vblank high, push at cycle t.
    vblank = 1'b1;
    set_cmd(1'b1, 2'b00, 6'd5, 16'h1234, 8'd40, 8'd20);
    step();                                   // t+1
    set_cmd(1'b0, 2'b11, 6'd0, 16'h0, 8'h0, 8'h0);
    check("t1_active_t1", 64'(program_active), 64'd0);
    check("t1_busy_t1", 64'(busy), 64'd1);
    step();                                   // t+2
    check("t1_bus_t2", {23'h0, program_active, requested_sprite_id, set_address, setx, sety, clear},
          {23'h0, 1'b1, 6'd5, 16'h1234, 8'd40, 8'd20, 1'b0});
    repeat (8) step();                        // t+10
    check("t1_bus_t10", {23'h0, program_active, requested_sprite_id, set_address, setx, sety, clear},
          {23'h0, 1'b1, 6'd5, 16'h1234, 8'd40, 8'd20, 1'b0});
    step();                                   // t+11 gap
    check("t1_gap_t11", {program_active, requested_sprite_id, set_address}, 23'h0);
    step();                                   // t+12
    check("t1_busy_t12", 64'(busy), 64'd0);

    // 2: five SETs with vblank low, only four fit.
    vblank = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_cmd(1'b1, 2'b00, 6'(10 + i), 16'(16'hA000 + i), 8'(i), 8'(2 * i));
      check("t2_ready", 64'(cmd_ready), (i < 4) ? 64'd1 : 64'd0);
      step();
    end
    set_cmd(1'b0, 2'b11, 6'd0, 16'h0, 8'h0, 8'h0);
    repeat (3) step();
    check("t2_no_drive", 64'(program_active), 64'd0);
    vblank = 1'b1;
    wait_drain("t2_drain", 200);

    // 3: CLEAR_ALL sweep of ids 0..NS-1.
    set_cmd(1'b1, 2'b10, 6'd33, 16'h0, 8'h0, 8'h0);
    step();
    set_cmd(1'b0, 2'b11, 6'd0, 16'h0, 8'h0, 8'h0);
    wait_drain("t3_drain", 200);

    // 4: CLEAR_ALL paused after id 1 and resumed at id 2.
    set_cmd(1'b1, 2'b10, 6'd0, 16'h0, 8'h0, 8'h0);
    step();
    set_cmd(1'b0, 2'b11, 6'd0, 16'h0, 8'h0, 8'h0);
    begin
      int n = 0;
      while (!(program_active && requested_sprite_id == 6'd1) && n < 100) begin step(); n++; end
      check("t4_reach_id1", 64'(requested_sprite_id), 64'd1);
    end
    vblank = 1'b0;
    repeat (12) step();
    check("t4_paused_active", 64'(program_active), 64'd0);
    check("t4_paused_busy", 64'(busy), 64'd1);
    vblank = 1'b1;
    wait_active("t4_resume", 20);
    check("t4_resume_id", 64'(requested_sprite_id), 64'd2);
    wait_drain("t4_drain", 200);

    // 5: NOP is accepted and dropped.
    set_cmd(1'b1, 2'b11, 6'd9, 16'hFFFF, 8'hFF, 8'hFF);
    check("t5_ready", 64'(cmd_ready), 64'd1);
    step();
    set_cmd(1'b0, 2'b11, 6'd0, 16'h0, 8'h0, 8'h0);
    for (int i = 0; i < 3; i++) begin
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_active", 64'(program_active), 64'd0);
      step();
    end

    // 6: reset in the middle of a DRIVE.
    set_cmd(1'b1, 2'b00, 6'd7, 16'hBEEF, 8'd1, 8'd2);
    step();
    set_cmd(1'b1, 2'b01, 6'd8, 16'h0, 8'h0, 8'h0);
    step();
    set_cmd(1'b0, 2'b11, 6'd0, 16'h0, 8'h0, 8'h0);
    wait_active("t6_start", 20);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_after_reset",
          {22'h0, program_active, requested_sprite_id, set_address, setx, sety, clear, busy, cmd_ready},
          64'd1);

    // Randomized traffic against the model, including ids beyond NS and stray resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 19) == 0) vblank = ~vblank;
      reset = ($urandom_range(0, 499) == 0);
      set_cmd(1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 2'b10 : 2'($urandom_range(0, 3)),
              6'($urandom_range(0, 63)), 16'($urandom), 8'($urandom), 8'($urandom));
      step();
    end
    reset = 1'b0; vblank = 1'b1;
    set_cmd(1'b0, 2'b11, 6'd0, 16'h0, 8'h0, 8'h0);
    wait_drain("final_drain", 500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
